// File: rtl/rat_loader_pkg.sv
// Shared definitions for the program-image loader.
// Holds the default geometry of the program memory and the loader FSM
// state encoding, plus a decode of which states accept an RX byte.
package rat_loader_pkg;

  localparam int ADDR_W    = 10;    // program-memory address width
  localparam int DATA_W    = 18;    // instruction width
  localparam int MAX_WORDS = 1024;  // largest legal image length in words

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    BYTE0,
    BYTE1,
    BYTE2,
    WRITE,
    CHECK,
    FAIL
  } state_t;

  // States in which the loader consumes a byte from the RX stream.
  function automatic logic rx_ready_in(input state_t s);
    return (s inside {LEN_HI, LEN_LO, BYTE0, BYTE1, BYTE2, CHECK});
  endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader: receives a program image over a byte stream and writes it
// into program memory while holding the MCU in reset.
// Stream: LEN_HI, LEN_LO (word count N), N x {B0,B1,B2}, checksum byte.
// Word written = {B0[1:0], B1, B2}; checksum = mod-256 sum of B0/B1/B2.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   START           level-sampled load request (honoured in IDLE and FAIL)
//   RX_DATA/VALID   incoming byte and its valid flag
//   RX_READY        loader accepts a byte this cycle
//   PROG_WE/WADDR/WDATA  program-memory write port, one strobe per word
//   CPU_HOLD        MCU held in reset while loading or after a failure
//   DONE            one-cycle pulse on a successful load
//   ERR             sticky error flag, cleared by START or RST
module prog_loader #(
  parameter int ADDR_W    = rat_loader_pkg::ADDR_W,
  parameter int DATA_W    = rat_loader_pkg::DATA_W,
  parameter int MAX_WORDS = rat_loader_pkg::MAX_WORDS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              PROG_WE,
  output logic [ADDR_W-1:0] PROG_WADDR,
  output logic [DATA_W-1:0] PROG_WDATA,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              ERR
);
  import rat_loader_pkg::*;

  localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

  state_t              r_state;
  logic [7:0]          r_len_hi;
  logic [15:0]         r_len;
  logic [15:0]         r_index;
  logic [7:0]          r_csum;
  logic [1:0]          r_b0;
  logic [7:0]          r_b1;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_hold;
  logic                r_done;
  logic                r_err;

  logic                w_rx_ready;
  logic                w_xfer;
  logic [15:0]         w_len;

  assign w_rx_ready = rx_ready_in(r_state);
  assign w_xfer     = RX_VALID & w_rx_ready;
  assign w_len      = {r_len_hi, RX_DATA};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_len_hi <= '0;
      r_len    <= '0;
      r_index  <= '0;
      r_csum   <= '0;
      r_b0     <= '0;
      r_b1     <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_hold   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_we   <= 1'b0;
      case (r_state)
        IDLE, FAIL: begin
          if (START) begin
            r_state <= LEN_HI;
            r_hold  <= 1'b1;
            r_err   <= 1'b0;
            r_index <= '0;
            r_csum  <= '0;
          end
        end
        LEN_HI: begin
          if (w_xfer) begin
            r_len_hi <= RX_DATA;
            r_state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (w_xfer) begin
            r_len <= w_len;
            if (w_len == '0 || {1'b0, w_len} > LP_MAX) begin
              r_state <= FAIL;
              r_err   <= 1'b1;
            end else begin
              r_state <= BYTE0;
            end
          end
        end
        BYTE0: begin
          if (w_xfer) begin
            if (RX_DATA[7:2] != '0) begin
              r_state <= FAIL;
              r_err   <= 1'b1;
            end else begin
              r_b0    <= RX_DATA[1:0];
              r_csum  <= r_csum + RX_DATA;
              r_state <= BYTE1;
            end
          end
        end
        BYTE1: begin
          if (w_xfer) begin
            r_b1    <= RX_DATA;
            r_csum  <= r_csum + RX_DATA;
            r_state <= BYTE2;
          end
        end
        BYTE2: begin
          // Write strobe and address/data are registered here so they are
          // valid for exactly the one cycle spent in WRITE.
          if (w_xfer) begin
            r_csum  <= r_csum + RX_DATA;
            r_we    <= 1'b1;
            r_waddr <= r_index[ADDR_W-1:0];
            r_wdata <= DATA_W'({r_b0, r_b1, RX_DATA});
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (r_index == r_len - 16'd1) begin
            r_state <= CHECK;
          end else begin
            r_index <= r_index + 16'd1;
            r_state <= BYTE0;
          end
        end
        CHECK: begin
          if (w_xfer) begin
            if (RX_DATA == r_csum) begin
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= FAIL;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign RX_READY   = w_rx_ready;
  assign PROG_WE    = r_we;
  assign PROG_WADDR = r_waddr;
  assign PROG_WDATA = r_wdata;
  assign CPU_HOLD   = r_hold;
  assign DONE       = r_done;
  assign ERR        = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random image streams checked against
// a stream-parsing reference model.
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic        PROG_WE;
  logic [9:0]  PROG_WADDR;
  logic [17:0] PROG_WDATA;
  logic        CPU_HOLD;
  logic        DONE;
  logic        ERR;

  always #5 CLK = ~CLK;

  prog_loader #(.ADDR_W(10), .DATA_W(18), .MAX_WORDS(1024)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .PROG_WE(PROG_WE), .PROG_WADDR(PROG_WADDR), .PROG_WDATA(PROG_WDATA),
    .CPU_HOLD(CPU_HOLD), .DONE(DONE), .ERR(ERR)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0]  stim[$];
  logic [31:0] wlog[$];
  logic [31:0] m_w[$];
  int unsigned done_cnt = 0;
  int unsigned m_used;
  bit          m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write log entry = addr * 2^18 + data.
  always @(negedge CLK) begin
    if (PROG_WE === 1'b1) wlog.push_back({4'b0, PROG_WADDR, PROG_WDATA});
    if (DONE === 1'b1) done_cnt++;
  end

  // Reference: parse the stream, returning bytes the loader will consume,
  // the expected writes and whether the load succeeds.
  function automatic void model();
    int unsigned n, p, sum, b0, b1, b2;
    m_w.delete();
    m_done = 0;
    n = int'(stim[0]) * 256 + int'(stim[1]);
    m_used = 2;
    if (n == 0 || n > 1024) return;
    sum = 0;
    for (int w = 0; w < int'(n); w++) begin
      p = 2 + 3 * w;
      b0 = int'(stim[p]);
      m_used++;
      if (b0 > 3) return;
      b1 = int'(stim[p+1]);
      b2 = int'(stim[p+2]);
      m_used += 2;
      m_w.push_back(w * 262144 + b0 * 65536 + b1 * 256 + b2);
      sum += b0 + b1 + b2;
    end
    m_used++;
    m_done = (int'(stim[2 + 3 * n]) == sum % 256);
  endfunction

  function automatic void build(input int unsigned n, input bit good_sum);
    int unsigned sum;
    logic [7:0] b;
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    sum = 0;
    for (int w = 0; w < int'(n); w++) begin
      b = 8'($urandom_range(3, 0));
      stim.push_back(b); sum += b;
      b = 8'($urandom); stim.push_back(b); sum += b;
      b = 8'($urandom); stim.push_back(b); sum += b;
    end
    stim.push_back(good_sum ? 8'(sum) : 8'(sum + 1));
  endfunction

  task automatic do_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("hold_on_start", CPU_HOLD, 1);
    chk("err_clr_start", ERR, 0);
    chk("ready_lenhi", RX_READY, 1);
  endtask

  task automatic send(input int unsigned n, input int unsigned gap);
    int unsigned cyc;
    for (int i = 0; i < int'(n); i++) begin
      repeat (gap != 0 ? $urandom_range(gap, 0) : 0) begin
        @(negedge CLK);
        RX_VALID = 1'b0;
      end
      @(negedge CLK);
      RX_VALID = 1'b1;
      RX_DATA  = stim[i];
      cyc = 0;
      while (RX_READY !== 1'b1 && cyc < 50) begin
        @(negedge CLK);
        cyc++;
      end
      if (cyc >= 50) begin
        chk("rx_timeout", 1, 0);
        RX_VALID = 1'b0;
        return;
      end
      @(posedge CLK);
    end
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  task automatic run_load(input string tag, input int unsigned gap);
    int unsigned nw;
    model();
    wlog.delete();
    done_cnt = 0;
    do_start();
    send(m_used, gap);
    repeat (6) @(negedge CLK);
    chk({tag, "_nwr"}, wlog.size(), m_w.size());
    nw = (wlog.size() < m_w.size()) ? wlog.size() : m_w.size();
    for (int i = 0; i < int'(nw); i++) chk({tag, "_wr"}, wlog[i], m_w[i]);
    chk({tag, "_done"}, done_cnt, m_done ? 1 : 0);
    chk({tag, "_hold"}, CPU_HOLD, m_done ? 0 : 1);
    chk({tag, "_err"}, ERR, m_done ? 0 : 1);
    chk({tag, "_rdy"}, RX_READY, 0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; RX_VALID = 1'b0; RX_DATA = '0;
    #12;
    chk("rst_ready", RX_READY, 0);
    chk("rst_we", PROG_WE, 0);
    chk("rst_waddr", PROG_WADDR, 0);
    chk("rst_wdata", PROG_WDATA, 0);
    chk("rst_hold", CPU_HOLD, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 2-word image with correct checksum
    stim = '{8'h00, 8'h02, 8'h03, 8'hFF, 8'h01, 8'h00, 8'h12, 8'h34, 8'h49};
    run_load("two_word", 0);
    if (wlog.size() >= 2) begin
      chk("two_word_w0", wlog[0], 32'h0003FF01);
      chk("two_word_w1", wlog[1], 32'h00041234);
    end
    chk("two_word_done1", done_cnt, 1);

    // same stream, bad checksum
    stim = '{8'h00, 8'h02, 8'h03, 8'hFF, 8'h01, 8'h00, 8'h12, 8'h34, 8'h48};
    run_load("bad_sum", 1);
    chk("bad_sum_nwr2", wlog.size(), 2);

    // illegal lengths (second run restarts from FAIL)
    stim = '{8'h00, 8'h00};
    run_load("len_zero", 0);
    chk("len_zero_nowr", wlog.size(), 0);
    stim = '{8'h04, 8'h01};
    run_load("len_1025", 0);
    chk("len_1025_nowr", wlog.size(), 0);

    // bad B0 in word 0
    stim = '{8'h00, 8'h03, 8'h04, 8'h11, 8'h22};
    run_load("bad_b0", 0);
    chk("bad_b0_nowr", wlog.size(), 0);

    // random images, some with bad checksum or a bad B0
    for (int t = 0; t < 6; t++) begin
      build($urandom_range(8, 1), ($urandom_range(3, 0) != 0));
      if ($urandom_range(4, 0) == 0) stim[2 + 3 * $urandom_range(0, 0)] = 8'($urandom_range(255, 4));
      run_load("rand", 3);
    end

    // maximum length, random RX_VALID gaps
    build(1024, 1'b1);
    run_load("max_len", 3);
    chk("max_len_nwr", wlog.size(), 1024);
    if (wlog.size() == 1024) chk("max_len_last_addr", wlog[1023] >> 18, 1023);

    // reset during BYTE1 of word 5
    build(8, 1'b1);
    wlog.delete();
    do_start();
    send(18, 1);
    chk("mid_rdy_byte1", RX_READY, 1);
    chk("mid_nwr_before", wlog.size(), 5);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_we", PROG_WE, 0);
    chk("mid_rst_hold", CPU_HOLD, 0);
    chk("mid_rst_err", ERR, 0);
    chk("mid_rst_rdy", RX_READY, 0);
    chk("mid_rst_waddr", PROG_WADDR, 0);
    chk("mid_rst_wdata", PROG_WDATA, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    chk("mid_no_wr_after", wlog.size(), 5);
    build(1, 1'b1);
    run_load("after_rst", 0);
    if (wlog.size() >= 1) chk("after_rst_addr", wlog[0] >> 18, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
